// File: rtl/iq_pkg.sv
// Shared issue-queue definitions: default sizes, the allocator state type and
// one-hot helpers that work on any queue depth up to IQ_MAX_DEPTH.
package iq_pkg;

  localparam int IQ_DEPTH     = 8;
  localparam int IQ_ENQ_WIDTH = 2;
  localparam int IQ_MAX_DEPTH = 64;

  typedef enum logic {IQ_ALLOC_RUN, IQ_ALLOC_FLUSHED} iq_alloc_state_e;

  typedef logic [IQ_MAX_DEPTH-1:0] iq_vec_t;

  // Rotate left by one inside a 'width'-bit field, so bit width-1 wraps to bit 0.
  function automatic iq_vec_t rotl1(input iq_vec_t v, input int width);
    iq_vec_t mask;
    iq_vec_t r;
    mask = (width >= IQ_MAX_DEPTH) ? '1 : ((iq_vec_t'(1) << width) - iq_vec_t'(1));
    r    = {v[IQ_MAX_DEPTH-2:0], 1'b0} & mask;
    r[0] = v[6'(width - 1)];
    return r;
  endfunction

  function automatic iq_vec_t highest_set_oh(input iq_vec_t v);
    iq_vec_t r;
    r = '0;
    for (int i = 0; i < IQ_MAX_DEPTH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_circ_pick.sv
// Circular first-one picker: returns the first set bit of req at or after the
// one-hot base, wrapping from bit WIDTH-1 to bit 0.
module iq_circ_pick #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base_oh,
  output logic [WIDTH-1:0] gnt_oh
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] first;

  // Lower copy keeps only bits at/above the base; the upper copy covers the wrap.
  always_comb begin
    dbl    = {req, req & ~(base_oh - WIDTH'(1))};
    first  = dbl & (~dbl + (2*WIDTH)'(1));
    gnt_oh = first[WIDTH-1:0] | first[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/iq_enq_alloc_multi.sv
// Multi-port enqueue slot allocator: hands in-order dispatch requests distinct
// free issue-queue entries, searching circularly from a registered pointer.
module iq_enq_alloc_multi
  import iq_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int ENQ_WIDTH = IQ_ENQ_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [DEPTH-1:0]           valid_vec,
  input  logic [DEPTH-1:0]           deq_ptr_oh,
  input  logic [ENQ_WIDTH-1:0]       enq_req,
  output logic [ENQ_WIDTH-1:0]       enq_gnt,
  output logic [ENQ_WIDTH*DEPTH-1:0] enq_slot_oh,
  output logic [DEPTH-1:0]           enq_ptr_oh,
  output logic [$clog2(DEPTH):0]     free_cnt,
  output logic                       alloc_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_alloc_state_e state;

  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] used;
  logic [DEPTH-1:0] rem;
  logic [DEPTH-1:0] last_slot;
  logic [DEPTH-1:0] next_base;
  logic [DEPTH-1:0] rem_pick;
  logic [DEPTH-1:0] ptr_flush;
  logic [DEPTH-1:0] ptr_next;
  logic [DEPTH-1:0] avail [ENQ_WIDTH];
  logic [DEPTH-1:0] cand  [ENQ_WIDTH];
  logic             allow;
  logic             chain;

  assign free  = ~valid_vec;
  assign allow = ~reset & ~flush & (state == IQ_ALLOC_RUN);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_cnt = free_cnt + CNT_W'(free[i]);
    end
  end

  // Each port searches what the older ports left behind, all from the same base.
  assign avail[0] = free;

  for (genvar p = 0; p < ENQ_WIDTH; p++) begin : g_port
    iq_circ_pick #(.WIDTH(DEPTH)) u_pick (
      .req     (avail[p]),
      .base_oh (enq_ptr_oh),
      .gnt_oh  (cand[p])
    );
    if (p + 1 < ENQ_WIDTH) begin : g_next
      assign avail[p+1] = avail[p] & ~cand[p];
    end
  end

  always_comb begin
    enq_gnt     = '0;
    enq_slot_oh = '0;
    used        = '0;
    last_slot   = '0;
    chain       = allow;
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      chain      = chain & enq_req[p] & (free_cnt >= CNT_W'(p + 1));
      enq_gnt[p] = chain;
      if (chain) begin
        enq_slot_oh[p*DEPTH +: DEPTH] = cand[p];
        used                          = used | cand[p];
        last_slot                     = cand[p];
      end
    end
  end

  assign rem = free & ~used;

  always_comb begin
    next_base = DEPTH'(rotl1(iq_vec_t'(last_slot), DEPTH));
    ptr_flush = DEPTH'(rotl1(highest_set_oh(iq_vec_t'(valid_vec)), DEPTH));
  end

  iq_circ_pick #(.WIDTH(DEPTH)) u_ptr_pick (
    .req     (rem),
    .base_oh (next_base),
    .gnt_oh  (rem_pick)
  );

  always_comb begin
    ptr_next = enq_ptr_oh;
    if (state == IQ_ALLOC_FLUSHED) begin
      ptr_next = (|valid_vec) ? ptr_flush : deq_ptr_oh;
    end else if (rem == '0) begin
      ptr_next = deq_ptr_oh;
    end else if (|enq_gnt) begin
      ptr_next = rem_pick;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IQ_ALLOC_RUN;
      enq_ptr_oh <= DEPTH'(1);
    end else begin
      state      <= flush ? IQ_ALLOC_FLUSHED : IQ_ALLOC_RUN;
      enq_ptr_oh <= ptr_next;
    end
  end

  assign alloc_busy = (state == IQ_ALLOC_FLUSHED) & ~reset;

  a_ptr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot(enq_ptr_oh));
  a_disjoint:   assert property (@(posedge clock) $countones(used) == $countones(enq_gnt));
  a_subset:     assert property (@(posedge clock) (used & valid_vec) == '0);

  for (genvar p = 0; p < ENQ_WIDTH; p++) begin : g_slot_chk
    a_slot_onehot0: assert property (@(posedge clock) $onehot0(enq_slot_oh[p*DEPTH +: DEPTH]));
  end

endmodule

// File: tb/tb_iq_enq_alloc_multi.sv
// Directed and model-checked bench for the issue-queue enqueue allocator (DEPTH=8, two ports).
module tb_iq_enq_alloc_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  valid_vec = 8'h00;
  logic [7:0]  deq_ptr_oh = 8'h01;
  logic [1:0]  enq_req = 2'b00;
  logic [1:0]  enq_gnt;
  logic [15:0] enq_slot_oh;
  logic [7:0]  enq_ptr_oh;
  logic [3:0]  free_cnt;
  logic        alloc_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  iq_enq_alloc_multi #(.DEPTH(8), .ENQ_WIDTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .valid_vec   (valid_vec),
    .deq_ptr_oh  (deq_ptr_oh),
    .enq_req     (enq_req),
    .enq_gnt     (enq_gnt),
    .enq_slot_oh (enq_slot_oh),
    .enq_ptr_oh  (enq_ptr_oh),
    .free_cnt    (free_cnt),
    .alloc_busy  (alloc_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are looked at 1 time unit later.
  task automatic drive(input logic r, input logic f, input logic [7:0] v,
                       input logic [7:0] d, input logic [1:0] q);
    @(negedge clock);
    reset      = r;
    flush      = f;
    valid_vec  = v;
    deq_ptr_oh = d;
    enq_req    = q;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 8'h01, 2'b11);
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b want 00", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0000) begin tests_failed++; $display("FAIL reset_slots: got %h want 0000", enq_slot_oh); end
    tests_run++; if (alloc_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", alloc_busy); end
    tests_run++; if (enq_ptr_oh !== 8'h01) begin tests_failed++; $display("FAIL reset_ptr: got %h want 01", enq_ptr_oh); end
  endtask

  task automatic test_basic_alloc();
    drive(0, 0, 8'h00, 8'h01, 2'b11);
    tests_run++; if (enq_gnt !== 2'b11) begin tests_failed++; $display("FAIL basic_gnt: got %b want 11", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0201) begin tests_failed++; $display("FAIL basic_slots: got %h want 0201", enq_slot_oh); end
    tests_run++; if (free_cnt !== 4'd8) begin tests_failed++; $display("FAIL basic_free_cnt: got %0d want 8", free_cnt); end
    drive(0, 0, 8'h00, 8'h01, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h04) begin tests_failed++; $display("FAIL basic_next_ptr: got %h want 04", enq_ptr_oh); end
  endtask

  task automatic test_fill_to_full();
    drive(0, 1, 8'h00, 8'h01, 2'b00);
    tests_run++; if (alloc_busy !== 1'b0) begin tests_failed++; $display("FAIL fill_busy_flush: got %b want 0", alloc_busy); end
    drive(0, 0, 8'h3F, 8'h01, 2'b11);
    tests_run++; if (alloc_busy !== 1'b1) begin tests_failed++; $display("FAIL fill_busy_flushed: got %b want 1", alloc_busy); end
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL fill_gnt_flushed: got %b want 00", enq_gnt); end
    drive(0, 0, 8'h3F, 8'h02, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h40) begin tests_failed++; $display("FAIL fill_realigned_ptr: got %h want 40", enq_ptr_oh); end
    tests_run++; if (enq_gnt !== 2'b11) begin tests_failed++; $display("FAIL fill_gnt: got %b want 11", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h8040) begin tests_failed++; $display("FAIL fill_slots: got %h want 8040", enq_slot_oh); end
    tests_run++; if (free_cnt !== 4'd2) begin tests_failed++; $display("FAIL fill_free_cnt: got %0d want 2", free_cnt); end
    drive(0, 0, 8'hFF, 8'h20, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h02) begin tests_failed++; $display("FAIL fill_ptr_deq: got %h want 02", enq_ptr_oh); end
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL full_gnt: got %b want 00", enq_gnt); end
    tests_run++; if (free_cnt !== 4'd0) begin tests_failed++; $display("FAIL full_free_cnt: got %0d want 0", free_cnt); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 8'h00, 8'h20, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h20) begin tests_failed++; $display("FAIL full_ptr_deq: got %h want 20", enq_ptr_oh); end
    drive(0, 0, 8'h40, 8'h20, 2'b00);
    drive(0, 0, 8'h7E, 8'h10, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h80) begin tests_failed++; $display("FAIL wrap_realigned_ptr: got %h want 80", enq_ptr_oh); end
    tests_run++; if (enq_gnt !== 2'b11) begin tests_failed++; $display("FAIL wrap_gnt: got %b want 11", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0180) begin tests_failed++; $display("FAIL wrap_slots: got %h want 0180", enq_slot_oh); end
    drive(0, 0, 8'h00, 8'h10, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h10) begin tests_failed++; $display("FAIL wrap_ptr_deq: got %h want 10", enq_ptr_oh); end
  endtask

  task automatic test_partial_grant();
    drive(0, 0, 8'hFB, 8'h01, 2'b11);
    tests_run++; if (enq_gnt !== 2'b01) begin tests_failed++; $display("FAIL partial_gnt: got %b want 01", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0004) begin tests_failed++; $display("FAIL partial_slots: got %h want 0004", enq_slot_oh); end
    tests_run++; if (free_cnt !== 4'd1) begin tests_failed++; $display("FAIL partial_free_cnt: got %0d want 1", free_cnt); end
    drive(0, 0, 8'hFB, 8'h20, 2'b10);
    tests_run++; if (enq_ptr_oh !== 8'h01) begin tests_failed++; $display("FAIL partial_ptr_deq: got %h want 01", enq_ptr_oh); end
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL gap_gnt: got %b want 00", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0000) begin tests_failed++; $display("FAIL gap_slots: got %h want 0000", enq_slot_oh); end
    drive(0, 0, 8'h00, 8'h20, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h01) begin tests_failed++; $display("FAIL gap_ptr_hold: got %h want 01", enq_ptr_oh); end
  endtask

  task automatic test_flush();
    drive(0, 1, 8'h00, 8'h01, 2'b11);
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL flush_gnt: got %b want 00", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0000) begin tests_failed++; $display("FAIL flush_slots: got %h want 0000", enq_slot_oh); end
    drive(0, 0, 8'h0C, 8'h01, 2'b11);
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL flushed_gnt: got %b want 00", enq_gnt); end
    tests_run++; if (alloc_busy !== 1'b1) begin tests_failed++; $display("FAIL flushed_busy: got %b want 1", alloc_busy); end
    tests_run++; if (enq_ptr_oh !== 8'h01) begin tests_failed++; $display("FAIL flush_ptr_hold: got %h want 01", enq_ptr_oh); end
    drive(0, 0, 8'h00, 8'h01, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h10) begin tests_failed++; $display("FAIL flushed_ptr: got %h want 10", enq_ptr_oh); end
    tests_run++; if (alloc_busy !== 1'b0) begin tests_failed++; $display("FAIL flushed_busy_clear: got %b want 0", alloc_busy); end
  endtask

  task automatic test_flushed_empty_and_reset();
    drive(0, 1, 8'h00, 8'h01, 2'b00);
    drive(0, 1, 8'h00, 8'h08, 2'b11);
    tests_run++; if (alloc_busy !== 1'b1) begin tests_failed++; $display("FAIL reflush_busy: got %b want 1", alloc_busy); end
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL reflush_gnt: got %b want 00", enq_gnt); end
    drive(1, 1, 8'h00, 8'h08, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h08) begin tests_failed++; $display("FAIL empty_flushed_ptr: got %h want 08", enq_ptr_oh); end
    tests_run++; if (alloc_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_in_flushed_busy: got %b want 0", alloc_busy); end
    tests_run++; if (enq_gnt !== 2'b00) begin tests_failed++; $display("FAIL reset_in_flushed_gnt: got %b want 00", enq_gnt); end
    drive(0, 0, 8'h00, 8'h08, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h01) begin tests_failed++; $display("FAIL reset_win_ptr: got %h want 01", enq_ptr_oh); end
    tests_run++; if (alloc_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_win_busy: got %b want 0", alloc_busy); end
    tests_run++; if (enq_slot_oh !== 16'h0201) begin tests_failed++; $display("FAIL reset_win_slots: got %h want 0201", enq_slot_oh); end
    drive(0, 0, 8'h00, 8'h08, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h04) begin tests_failed++; $display("FAIL reset_win_next_ptr: got %h want 04", enq_ptr_oh); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 8'h00, 8'h01, 2'b01);
    tests_run++; if (enq_gnt !== 2'b01) begin tests_failed++; $display("FAIL b2b1_gnt: got %b want 01", enq_gnt); end
    tests_run++; if (enq_slot_oh !== 16'h0004) begin tests_failed++; $display("FAIL b2b1_slots: got %h want 0004", enq_slot_oh); end
    drive(0, 0, 8'h18, 8'h01, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h08) begin tests_failed++; $display("FAIL b2b2_ptr: got %h want 08", enq_ptr_oh); end
    tests_run++; if (enq_slot_oh !== 16'h4020) begin tests_failed++; $display("FAIL b2b2_slots: got %h want 4020", enq_slot_oh); end
    drive(0, 0, 8'h00, 8'h01, 2'b11);
    tests_run++; if (enq_ptr_oh !== 8'h80) begin tests_failed++; $display("FAIL b2b3_ptr: got %h want 80", enq_ptr_oh); end
    tests_run++; if (enq_slot_oh !== 16'h0180) begin tests_failed++; $display("FAIL b2b3_slots: got %h want 0180", enq_slot_oh); end
    drive(0, 0, 8'h00, 8'h01, 2'b00);
    tests_run++; if (enq_ptr_oh !== 8'h02) begin tests_failed++; $display("FAIL b2b4_ptr: got %h want 02", enq_ptr_oh); end
  endtask

  function automatic int find_circ(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  // Index-based reference model; enters with the pointer at slot 1 in RUN.
  task automatic test_random_stress();
    int         mp = 1;
    bit         mflushed = 1'b0;
    logic [7:0] fr, taken, rm, v, d;
    logic [1:0] q, eg;
    logic [15:0] es;
    logic       f;
    bit         ok;
    int         cnt, s, last, hi;
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 9) == 0);
      v = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 5) == 0) v = 8'hFF;
      d = 8'h01 << $urandom_range(0, 7);
      q = 2'($urandom_range(0, 3));
      drive(0, f, v, d, q);
      fr = ~v; cnt = 0;
      for (int i = 0; i < 8; i++) cnt += int'(fr[i]);
      taken = '0; eg = '0; es = '0; last = -1;
      ok = !f && !mflushed;
      for (int p = 0; p < 2; p++) begin
        ok = ok && q[p] && (cnt >= p + 1);
        if (ok) begin
          s = find_circ(fr & ~taken, mp);
          eg[p] = 1'b1; es[p*8 + s] = 1'b1; taken[s] = 1'b1; last = s;
        end
      end
      tests_run++; if (enq_ptr_oh !== (8'h01 << mp)) begin tests_failed++; $display("FAIL rand_ptr[%0d]: got %h want %h", n, enq_ptr_oh, 8'h01 << mp); end
      tests_run++; if (enq_gnt !== eg) begin tests_failed++; $display("FAIL rand_gnt[%0d]: got %b want %b", n, enq_gnt, eg); end
      tests_run++; if (enq_slot_oh !== es) begin tests_failed++; $display("FAIL rand_slots[%0d]: got %h want %h", n, enq_slot_oh, es); end
      rm = fr & ~taken;
      if (mflushed) begin
        if (v != 0) begin
          hi = 0;
          for (int i = 0; i < 8; i++) if (v[i]) hi = i;
          mp = (hi + 1) % 8;
        end else begin
          mp = find_circ(d, 0);
        end
      end else if (rm == 0) begin
        mp = find_circ(d, 0);
      end else if (last >= 0) begin
        mp = find_circ(rm, (last + 1) % 8);
      end
      mflushed = f;
    end
  endtask

  initial begin
    test_reset();
    test_basic_alloc();
    test_fill_to_full();
    test_wrap();
    test_partial_grant();
    test_flush();
    test_flushed_empty_and_reset();
    test_back_to_back();
    test_random_stress();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
